// File: rtl/bp_fe_ras_ckpt_pkg.sv
// Shared definitions for the checkpointed return address stack.
// Holds the stack operation encoding and the priority decode that picks
// one operation per cycle from the raw call/return/restore strobes.
package bp_fe_ras_ckpt_pkg;

    typedef enum logic [2:0] {
        RAS_IDLE,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP,
        RAS_RESTORE
    } ras_op_e;

    // Restore wins over everything. Call+return together replaces the top
    // entry in place. A return on an empty stack is dropped.
    function automatic ras_op_e ras_decode(input logic restore_v,
                                           input logic call,
                                           input logic ret,
                                           input logic nonempty);
        ras_op_e op;
        op = RAS_IDLE;
        if (restore_v)          op = RAS_RESTORE;
        else if (call && ret)   op = RAS_SWAP;
        else if (call)          op = RAS_PUSH;
        else if (ret && nonempty) op = RAS_POP;
        return op;
    endfunction

endpackage

// File: rtl/bp_fe_ras_storage.sv
// Target storage for the return address stack.
// One combinational read port, one synchronous write port, async reset to 0.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   w_v_i            write enable
//   w_addr_i         write index
//   w_data_i         write data
//   r_addr_i         read index
//   r_data_o         read data (combinational)
module bp_fe_ras_storage #(
    parameter int width_p = 39,
    parameter int els_p   = 8,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
        end else if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_ras_ckpt.sv
// Circular return address stack with speculative push/pop and checkpoint
// repair. ckpt_o = {tp, cnt, top entry} of the current state; feeding it back
// through restore_ckpt_i rewinds the pointer/count and rewrites the top slot,
// undoing a wrong-path push that clobbered it.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   call_i, addr_i   push addr_i
//   return_i         pop
//   tgt_o, v_o       top-of-stack target, stack non-empty
//   ckpt_o           checkpoint of the current state
//   restore_v_i      restore from restore_ckpt_i (overrides call/return)
//   restore_ckpt_i   checkpoint previously taken from ckpt_o
module bp_fe_ras_ckpt
    import bp_fe_ras_ckpt_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int ras_els_p     = 8,
    localparam int ptr_width_lp  = (ras_els_p > 1) ? $clog2(ras_els_p) : 1,
    localparam int cnt_width_lp  = $clog2(ras_els_p + 1),
    localparam int ckpt_width_lp = ptr_width_lp + cnt_width_lp + vaddr_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     call_i,
    input  logic [vaddr_width_p-1:0] addr_i,
    input  logic                     return_i,
    output logic [vaddr_width_p-1:0] tgt_o,
    output logic                     v_o,
    output logic [ckpt_width_lp-1:0] ckpt_o,
    input  logic                     restore_v_i,
    input  logic [ckpt_width_lp-1:0] restore_ckpt_i
);

    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(ras_els_p);

    logic [ptr_width_lp-1:0]  tp_r, tp_n;
    logic [cnt_width_lp-1:0]  cnt_r, cnt_n;
    logic                     w_we;
    logic [ptr_width_lp-1:0]  w_waddr;
    logic [vaddr_width_p-1:0] w_wdata;
    logic [vaddr_width_p-1:0] w_top;
    ras_op_e                  w_op;

    logic [ptr_width_lp-1:0]  w_rs_tp;
    logic [cnt_width_lp-1:0]  w_rs_cnt;
    logic [vaddr_width_p-1:0] w_rs_top;

    assign w_rs_tp  = restore_ckpt_i[ckpt_width_lp-1 -: ptr_width_lp];
    assign w_rs_cnt = restore_ckpt_i[vaddr_width_p+cnt_width_lp-1 -: cnt_width_lp];
    assign w_rs_top = restore_ckpt_i[vaddr_width_p-1:0];

    assign w_op = ras_decode(restore_v_i, call_i, return_i, (cnt_r != '0));

    always_comb begin
        tp_n    = tp_r;
        cnt_n   = cnt_r;
        w_we    = 1'b0;
        w_waddr = tp_r;
        w_wdata = addr_i;
        case (w_op)
            RAS_PUSH: begin
                // Pointer wraps modulo depth; when full the oldest slot is reused.
                tp_n    = tp_r + ptr_width_lp'(1);
                w_we    = 1'b1;
                w_waddr = tp_r + ptr_width_lp'(1);
                cnt_n   = (cnt_r == full_cnt_lp) ? full_cnt_lp : cnt_r + cnt_width_lp'(1);
            end
            RAS_POP: begin
                tp_n  = tp_r - ptr_width_lp'(1);
                cnt_n = cnt_r - cnt_width_lp'(1);
            end
            RAS_SWAP: begin
                w_we  = 1'b1;
                cnt_n = (cnt_r == '0) ? cnt_width_lp'(1) : cnt_r;
            end
            RAS_RESTORE: begin
                tp_n    = w_rs_tp;
                cnt_n   = w_rs_cnt;
                w_we    = 1'b1;
                w_waddr = w_rs_tp;
                w_wdata = w_rs_top;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tp_r  <= '0;
            cnt_r <= '0;
        end else begin
            tp_r  <= tp_n;
            cnt_r <= cnt_n;
        end
    end

    bp_fe_ras_storage #(
        .width_p (vaddr_width_p),
        .els_p   (ras_els_p)
    ) u_storage (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .w_v_i    (w_we),
        .w_addr_i (w_waddr),
        .w_data_i (w_wdata),
        .r_addr_i (tp_r),
        .r_data_o (w_top)
    );

    assign tgt_o  = w_top;
    assign v_o    = (cnt_r != '0);
    assign ckpt_o = {tp_r, cnt_r, w_top};

endmodule

// File: tb/tb_bp_fe_ras_ckpt.sv
module tb_bp_fe_ras_ckpt;

    localparam int VW  = 39;
    localparam int N   = 8;
    localparam int PW  = 3;
    localparam int CW  = 4;
    localparam int CKW = PW + CW + VW;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           call_i;
    logic [VW-1:0]  addr_i;
    logic           return_i;
    logic [VW-1:0]  tgt_o;
    logic           v_o;
    logic [CKW-1:0] ckpt_o;
    logic           restore_v_i;
    logic [CKW-1:0] restore_ckpt_i;

    bp_fe_ras_ckpt #(.vaddr_width_p(VW), .ras_els_p(N)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .call_i         (call_i),
        .addr_i         (addr_i),
        .return_i       (return_i),
        .tgt_o          (tgt_o),
        .v_o            (v_o),
        .ckpt_o         (ckpt_o),
        .restore_v_i    (restore_v_i),
        .restore_ckpt_i (restore_ckpt_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [VW-1:0]  tgt;
        logic           v;
        logic [CKW-1:0] ck;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Reference model of the stack.
    logic [VW-1:0] m_mem [N];
    int            m_tp;
    int            m_cnt;

    function automatic logic [CKW-1:0] model_ckpt();
        logic [PW-1:0] t;
        logic [CW-1:0] c;
        t = PW'(m_tp);
        c = CW'(m_cnt);
        return {t, c, m_mem[m_tp]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_tp  = 0;
        m_cnt = 0;
    endtask

    task automatic model_apply(input logic c, input logic r, input logic [VW-1:0] a,
                               input logic rv, input logic [CKW-1:0] rc);
        if (rv) begin
            m_tp  = int'(rc[CKW-1 -: PW]);
            m_cnt = int'(rc[VW+CW-1 -: CW]);
            m_mem[m_tp] = rc[VW-1:0];
        end else if (c && r) begin
            m_mem[m_tp] = a;
            if (m_cnt == 0) m_cnt = 1;
        end else if (c) begin
            m_tp = (m_tp + 1) % N;
            m_mem[m_tp] = a;
            if (m_cnt < N) m_cnt++;
        end else if (r) begin
            if (m_cnt != 0) begin
                m_tp = (m_tp + N - 1) % N;
                m_cnt--;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the model's post-edge state, then
    // compare it with the DUT after the edge.
    task automatic step(input logic c, input logic r, input logic [VW-1:0] a,
                        input logic rv, input logic [CKW-1:0] rc);
        exp_t e;
        call_i = c; return_i = r; addr_i = a;
        restore_v_i = rv; restore_ckpt_i = rc;
        model_apply(c, r, a, rv, rc);
        e.tgt = m_mem[m_tp];
        e.v   = (m_cnt != 0);
        e.ck  = model_ckpt();
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        e = exp_q.pop_front();
        check("sb_tgt",  64'(tgt_o),  64'(e.tgt));
        check("sb_v",    64'(v_o),    64'(e.v));
        check("sb_ckpt", 64'(ckpt_o), 64'(e.ck));
    endtask

    task automatic do_call(input logic [VW-1:0] a); step(1'b1, 1'b0, a, 1'b0, '0); endtask
    task automatic do_ret();                        step(1'b0, 1'b1, '0, 1'b0, '0); endtask
    task automatic do_idle();                       step(1'b0, 1'b0, '0, 1'b0, '0); endtask

    function automatic logic [63:0] dut_cnt();
        return 64'(ckpt_o[VW+CW-1 -: CW]);
    endfunction

    logic [CKW-1:0] saved_ck;

    initial begin
        model_reset();
        reset_i = 1'b1; call_i = 1'b0; return_i = 1'b0; addr_i = '0;
        restore_v_i = 1'b0; restore_ckpt_i = '0;
        #12;
        check("rst_tgt",  64'(tgt_o),  64'h0);
        check("rst_v",    64'(v_o),    64'h0);
        check("rst_ckpt", 64'(ckpt_o), 64'h0);
        reset_i = 1'b0;

        // Basic push/pop
        do_call(39'h100); do_call(39'h200); do_call(39'h300);
        check("push3_tgt", 64'(tgt_o), 64'h300);
        check("push3_v",   64'(v_o),   64'h1);
        check("push3_cnt", dut_cnt(),  64'h3);
        do_ret(); check("pop1_tgt", 64'(tgt_o), 64'h200);
        do_ret(); check("pop2_tgt", 64'(tgt_o), 64'h100);
        do_ret(); check("pop3_v",   64'(v_o),   64'h0);

        // Overflow wrap: 9 pushes into 8 slots
        for (int i = 1; i <= 9; i++) do_call(VW'(i * 'h10));
        check("full_cnt", dut_cnt(),  64'h8);
        check("full_tgt", 64'(tgt_o), 64'h90);
        for (int i = 0; i < 8; i++) begin
            check("wrap_pop_seq", 64'(tgt_o), 64'(64'h90 - 64'(i) * 64'h10));
            do_ret();
        end
        check("wrap_empty_v", 64'(v_o), 64'h0);

        // Underflow ignored
        do_ret();
        check("under_v",   64'(v_o),  64'h0);
        check("under_cnt", dut_cnt(), 64'h0);
        do_call(39'h40);
        check("under_call_tgt", 64'(tgt_o), 64'h40);
        check("under_call_v",   64'(v_o),   64'h1);

        // Call+return in the same cycle
        do_call(39'h300);
        step(1'b1, 1'b1, 39'h500, 1'b0, '0);
        check("swap_tgt", 64'(tgt_o), 64'h500);
        check("swap_cnt", dut_cnt(),  64'h2);
        do_ret();
        check("swap_pop_tgt", 64'(tgt_o), 64'h40);

        // Checkpoint and restore after wrong-path activity
        do_call(39'h200);
        saved_ck = model_ckpt();
        check("ckpt_take", 64'(ckpt_o), 64'(saved_ck));
        step(1'b1, 1'b1, 39'h900, 1'b0, '0);
        do_call(39'hA00);
        check("wrong_tgt", 64'(tgt_o), 64'hA00);
        step(1'b0, 1'b0, '0, 1'b1, saved_ck);
        check("restore_tgt", 64'(tgt_o), 64'h200);
        check("restore_cnt", dut_cnt(),  64'h2);
        do_call(39'hA00);
        step(1'b1, 1'b0, 39'hBBB, 1'b1, saved_ck);
        check("restore_call_tgt", 64'(tgt_o), 64'h200);
        check("restore_call_cnt", dut_cnt(),  64'h2);

        // Asynchronous reset between clock edges
        do_call(39'h111);
        do_call(39'h222);
        #3;
        reset_i = 1'b1;
        #1;
        check("arst_v",    64'(v_o),    64'h0);
        check("arst_tgt",  64'(tgt_o),  64'h0);
        check("arst_ckpt", 64'(ckpt_o), 64'h0);
        model_reset();
        call_i = 1'b1; addr_i = 39'h333;
        @(posedge clk_i); #1;
        check("arst_hold_v", 64'(v_o), 64'h0);
        reset_i = 1'b0;
        do_idle();
        do_call(39'h444);
        check("post_rst_tgt", 64'(tgt_o), 64'h444);
        check("post_rst_cnt", dut_cnt(),  64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
